sc_et_decoder: RTL and testbench



---
 rtl/sc_et_decoder_if.sv | 31 +++
 rtl/sc_et_decoder.sv | 108 ++++++++++
 tb/tb_sc_et_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sc_et_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_et_decoder_if
// Brief    : Control, bitstream and result handshake bundle for sc_et_decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface sc_et_decoder_if #(
    parameter int W  = 6,
    parameter int PW = $clog2(W + 1)
);
    logic          start;
    logic [PW-1:0] prec;
    logic          bit_in;
    logic          bit_valid;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W:0]    ones_cnt;

    modport master (
        output start, prec, bit_in, bit_valid, out_ready,
        input  busy, out_valid, result, ones_cnt
    );

    modport slave (
        input  start, prec, bit_in, bit_valid, out_ready,
        output busy, out_valid, result, ones_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sc_et_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sc_et_decoder
// Brief    : Stochastic-to-binary decoder with per-operation stream length 2^p.
// Revision : 1.0 - initial release
// ============================================================================
module sc_et_decoder #(
    parameter int W  = 6,
    parameter int PW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    sc_et_decoder_if.slave bus
);
    localparam logic [PW-1:0] C_PMAX = PW'(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [W:0]    cyc_q, cyc_d;
    logic [W:0]    ones_q, ones_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  result_q, result_d;

    logic [W:0]    w_target;
    logic [W:0]    w_cyc_inc;
    logic [PW-1:0] w_shamt;
    logic [W:0]    w_scaled;
    logic [W-1:0]  w_sat;

    assign w_target  = (W+1)'(1) << p_q;
    assign w_cyc_inc = cyc_q + (W+1)'(1);
    assign w_shamt   = C_PMAX - p_q;
    // ones <= 2^p, so the scaled value is at most 2^W and fits in W+1 bits
    assign w_scaled  = ones_q << w_shamt;
    assign w_sat     = w_scaled[W] ? {W{1'b1}} : w_scaled[W-1:0];

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cyc_d    = cyc_q;
        ones_d   = ones_q;
        valid_d  = valid_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    p_d     = (bus.prec > C_PMAX) ? C_PMAX : bus.prec;
                    cyc_d   = '0;
                    ones_d  = '0;
                end
            end
            S_RUN: begin
                if (bus.bit_valid) begin
                    cyc_d  = w_cyc_inc;
                    ones_d = ones_q + (W+1)'(bus.bit_in);
                    if (w_cyc_inc == w_target) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // First HOLD cycle registers the rescaled result from the frozen count
                if (!valid_q) begin
                    valid_d  = 1'b1;
                    result_d = w_sat;
                end else if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            cyc_q    <= '0;
            ones_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cyc_q    <= cyc_d;
            ones_q   <= ones_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.ones_cnt  = ones_q;
endmodule
`default_nettype wire

// File: tb/tb_sc_et_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sc_et_decoder
// Brief    : Table vectors, corner sequences and random ops against a count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_et_decoder;
    localparam int W  = 6;
    localparam int PW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_et_decoder_if #(.W(W), .PW(PW)) bus ();

    sc_et_decoder #(.W(W), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        int           prec;
        logic [255:0] bits;
        logic [255:0] vals;
        int           rdy;
        int           e_res;
        int           e_ones;
        int           e_lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beats are taken from bits/vals one per cycle after the start edge
    task automatic do_op(input string nm, input int pr, input logic [255:0] bits,
                         input logic [255:0] vals, input int rdy, input int e_res,
                         input int e_ones, input int e_lat, input bit rand_start);
        int  c;
        bit  got;
        int  res_seen;
        int  ones_seen;
        bus.start = 1'b1;
        bus.prec  = PW'(pr);
        tick();
        bus.start = 1'b0;
        check({nm, " busy_run"}, int'(bus.busy), 1);
        got = 1'b0;
        for (c = 1; c <= 256; c++) begin
            bus.bit_in    = bits[c-1];
            bus.bit_valid = vals[c-1];
            if (rand_start) bus.start = ($urandom_range(0, 3) == 0);
            tick();
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
        end
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        check({nm, " done"}, int'(got), 1);
        if (!got) return;
        check({nm, " latency"}, c, e_lat);
        check({nm, " result"}, int'(bus.result), e_res);
        check({nm, " ones_cnt"}, int'(bus.ones_cnt), e_ones);
        check({nm, " busy_hold"}, int'(bus.busy), 1);
        res_seen  = int'(bus.result);
        ones_seen = int'(bus.ones_cnt);
        for (int i = 0; i < rdy; i++) begin
            bus.start = (i == 0);
            tick();
            bus.start = 1'b0;
            check({nm, " hold_valid"}, int'(bus.out_valid), 1);
            check({nm, " hold_result"}, int'(bus.result), res_seen);
            check({nm, " hold_ones"}, int'(bus.ones_cnt), ones_seen);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({nm, " valid_drop"}, int'(bus.out_valid), 0);
        check({nm, " busy_drop"}, int'(bus.busy), 0);
    endtask

    initial begin
        tbl[0] = '{"full_1010", 6, {128{2'b01}}, '1, 5, 32, 32, 65};
        tbl[1] = '{"p3_1100",   3, {64{4'b0011}}, '1, 0, 32, 4, 9};
        tbl[2] = '{"p2_1110",   2, {64{4'b0111}}, '1, 0, 48, 3, 5};
        tbl[3] = '{"p6_ones",   6, '1, '1, 0, 63, 64, 65};
        tbl[4] = '{"p0_one",    0, '1, '1, 0, 63, 1, 2};
        tbl[5] = '{"p0_zero",   0, '0, '1, 0, 0, 0, 2};
        tbl[6] = '{"p7_clamp",  7, {128{2'b01}}, '1, 0, 32, 32, 65};
        tbl[7] = '{"p2_stall",  2, '1, {128{2'b01}}, 0, 63, 4, 8};
        tbl[8] = '{"p1_ready",  1, 256'b01, '1, 5, 32, 1, 3};
        tbl[9] = '{"p3_stall0", 3, '0, {64{4'b0101}}, 2, 0, 0, 16};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.prec      = '0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset busy", int'(bus.busy), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset result", int'(bus.result), 0);
        check("reset ones_cnt", int'(bus.ones_cnt), 0);
        rst = 1'b0;
        tick();

        // Back-to-back: each op starts the cycle after the previous handshake
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].name, tbl[i].prec, tbl[i].bits, tbl[i].vals, tbl[i].rdy,
                  tbl[i].e_res, tbl[i].e_ones, tbl[i].e_lat, 1'b0);
        end

        // Abort a long run after 10 beats
        bus.start = 1'b1;
        bus.prec  = PW'(6);
        tick();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.bit_in = 1'b1;
            tick();
        end
        check("midrun ones_cnt", int'(bus.ones_cnt), 10);
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.bit_valid = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort out_valid", int'(bus.out_valid), 0);
        check("abort result", int'(bus.result), 0);
        check("abort ones_cnt", int'(bus.ones_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort quiet", int'(bus.out_valid), 0);
        end
        do_op("after_abort", 1, 256'b01, '1, 0, 32, 1, 3, 1'b0);

        // Random ops against a count-and-scale model
        for (int t = 0; t < 24; t++) begin
            int           pr;
            int           p;
            int           n;
            int           cnt;
            int           ones;
            int           k;
            int           er;
            logic [255:0] b;
            logic [255:0] v;
            pr = $urandom_range(0, 7);
            for (int i = 0; i < 256; i++) begin
                b[i] = 1'($urandom_range(0, 1));
                v[i] = (i >= 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            p    = (pr > W) ? W : pr;
            n    = 1 << p;
            cnt  = 0;
            ones = 0;
            k    = 0;
            for (int i = 0; i < 256 && cnt < n; i++) begin
                if (v[i]) begin
                    cnt++;
                    ones += int'(b[i]);
                    k = i + 1;
                end
            end
            er = ones * (1 << (W - p));
            if (er > (1 << W) - 1) er = (1 << W) - 1;
            do_op($sformatf("rand%0d_p%0d", t, pr), pr, b, v, $urandom_range(0, 3),
                  er, ones, k + 1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
